// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: a shift-add multiplier and a restoring divider
// share one 2*WIDTH accumulator and execute UNROLL steps per cycle.
module mul_div_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             busy
);

  localparam int STEPS = WIDTH / UNROLL;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if ((WIDTH % UNROLL) != 0 || WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_param
      $error("mul_div_unit: WIDTH must be even, >= 4 and a multiple of UNROLL");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready is high only in IDLE; rsp_valid/rsp_r hold steady in DONE until rsp_ready.
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, mag_d;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, div_ovf, fast;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    a_signed = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    b_signed = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    neg_a    = a_signed && req_a[WIDTH-1];
    neg_b    = b_signed && req_b[WIDTH-1];
    abs_a    = neg_a ? -req_a : req_a;
    abs_b    = neg_b ? -req_b : req_b;
    div_zero = req_op[2] && (req_b == '0);
    div_ovf  = ((req_op == 3'd4) || (req_op == 3'd6)) && (req_a == MIN_NEG) && (req_b == '1);
    fast     = div_zero || div_ovf;
  end

  // One cycle's worth of iteration: multiplier/dividend lives in the low half.
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   tmp;
  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    tmp     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        tmp     = {step_hi, step_lo[WIDTH-1]};
        step_lo = {step_lo[WIDTH-2:0], 1'b0};
        if (tmp >= {1'b0, mag_d}) begin
          tmp        = tmp - {1'b0, mag_d};
          step_lo[0] = 1'b1;
        end
        step_hi = tmp[WIDTH-1:0];
      end else begin
        tmp     = step_lo[0] ? ({1'b0, step_hi} + {1'b0, mag_d}) : {1'b0, step_hi};
        step_lo = {tmp[0], step_lo[WIDTH-1:1]};
        step_hi = tmp[WIDTH:1];
      end
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_sel, fix_result;
  always_comb begin
    prod       = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    div_sel    = op_q[1] ? acc_hi : acc_lo;
    fix_result = '0;
    if (op_q[2])
      fix_result = neg_q ? -div_sel : div_sel;
    else if (op_q == 3'd0)
      fix_result = prod[WIDTH-1:0];
    else
      fix_result = prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = fast ? FIX : RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == DONE);
  end

  // Fast paths preload quotient into acc_lo and remainder into acc_hi, so FIX needs no extra mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_d  <= '0;
      cnt    <= '0;
      rsp_r  <= '0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        cnt  <= CW'(STEPS - 1);
        if (div_zero) begin
          acc_lo <= '1;
          acc_hi <= req_a;
          neg_q  <= 1'b0;
        end else if (div_ovf) begin
          acc_lo <= req_a;
          acc_hi <= '0;
          neg_q  <= 1'b0;
        end else begin
          acc_hi <= '0;
          acc_lo <= req_op[2] ? abs_a : abs_b;
          mag_d  <= req_op[2] ? abs_b : abs_a;
          neg_q  <= (req_op[2:1] == 2'b11) ? neg_a : (neg_a ^ neg_b);
        end
      end else if (state == RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt - CW'(1);
      end
      if (state == FIX) rsp_r <= fix_result;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, backpressure and reset sequences, and random
// operations checked against a plain-arithmetic model, on a 32/1 and a 16/4 instance.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        v32 = 0, rr32 = 0, rdy32, rv32, busy32;
  logic [2:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, r32;
  logic        v16 = 0, rr16 = 0, rdy16, rv16, busy16;
  logic [2:0]  op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, r16;

  mul_div_unit dut (
    .clk(clk), .reset_n(reset_n), .req_valid(v32), .req_ready(rdy32), .req_op(op32),
    .req_a(a32), .req_b(b32), .rsp_valid(rv32), .rsp_ready(rr32), .rsp_r(r32), .busy(busy32)
  );

  mul_div_unit #(.WIDTH(16), .UNROLL(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .req_valid(v16), .req_ready(rdy16), .req_op(op16),
    .req_a(a16), .req_b(b16), .rsp_valid(rv16), .rsp_ready(rr16), .rsp_r(r16), .busy(busy16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input int w); return (w == 32) ? rdy32 : rdy16; endfunction
  function automatic logic valid_of(input int w); return (w == 32) ? rv32 : rv16; endfunction
  function automatic logic busy_of(input int w);  return (w == 32) ? busy32 : busy16; endfunction
  function automatic logic [31:0] rsp_of(input int w);
    return (w == 32) ? r32 : {16'h0, r16};
  endfunction

  task automatic drive(input int w, input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (w == 32) begin
      v32 = v; op32 = op; a32 = a; b32 = b;
    end else begin
      v16 = v; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic set_rr(input int w, input logic v);
    if (w == 32) rr32 = v;
    else         rr16 = v;
  endtask

  // Reference: results from signed/unsigned 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] model(input int w, input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint mask, ua, ub, sa, sb;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
    p = '0;
    case (op)
      3'd0: p = 64'(sa * sb) & 64'(mask);
      3'd1: p = (64'(sa * sb) >> w) & 64'(mask);
      3'd2: p = (64'(sa * ub) >> w) & 64'(mask);
      3'd3: p = (64'(ua * ub) >> w) & 64'(mask);
      3'd4: p = (ub == 0) ? 64'(mask) : 64'(sa / sb) & 64'(mask);
      3'd5: p = (ub == 0) ? 64'(mask) : 64'(ua / ub);
      3'd6: p = (ub == 0) ? 64'(ua) : 64'(sa % sb) & 64'(mask);
      default: p = (ub == 0) ? 64'(ua) : 64'(ua % ub);
    endcase
    return p[31:0];
  endfunction

  function automatic int model_lat(input int w, input int unroll, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, min_neg;
    mask    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    min_neg = 32'h1 << (w - 1);
    if (op >= 3'd4 && (b & mask) == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && (a & mask) == min_neg && (b & mask) == mask) return 1;
    return w / unroll + 1;
  endfunction

  // Issue one op, wait for the response, optionally stall it 'hold' cycles with a competing request.
  task automatic do_op(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] r, output int lat, output int viol);
    viol = 0;
    if (!ready_of(w)) viol++;
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    lat = 0;
    while (!valid_of(w) && lat < 200) begin
      if (!busy_of(w) || ready_of(w)) viol++;
      @(posedge clk); #1;
      lat++;
    end
    r = rsp_of(w);
    for (int i = 0; i < hold; i++) begin
      drive(w, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
      @(posedge clk); #1;
      if (!valid_of(w) || rsp_of(w) !== r || ready_of(w) || !busy_of(w)) viol++;
    end
    set_rr(w, 1'b1);
    @(posedge clk); #1;
    set_rr(w, 1'b0);
    drive(w, 1'b0, 3'd0, 32'h0, 32'h0);
    if (valid_of(w) || !ready_of(w) || busy_of(w) || rsp_of(w) !== r) viol++;
  endtask

  typedef struct {
    int          w;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];
  logic [31:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, b, e;
    logic [2:0]  op;
    int lat, viol, w, unroll;

    vecs[0]  = '{32, 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{32, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{32, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{32, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{32, 3'd4, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{32, 3'd6, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE, 33};
    vecs[6]  = '{32, 3'd5, 32'hFFFF_FFEC, 32'h0000_0006, 32'h2AAA_AAA7, 33};
    vecs[7]  = '{32, 3'd7, 32'hFFFF_FFEC, 32'h0000_0006, 32'h0000_0002, 33};
    vecs[8]  = '{32, 3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{32, 3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    vecs[10] = '{32, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{32, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{16, 3'd0, 32'h0000_0123, 32'h0000_0010, 32'h0000_1230, 5};
    vecs[13] = '{16, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 1};

    #12;
    check("reset_ctrl32", {29'h0, rdy32, rv32, busy32}, 32'h4);
    check("reset_r32", r32, 32'h0);
    check("reset_ctrl16", {29'h0, rdy16, rv16, busy16}, 32'h4);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, 0, r, lat, viol);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_handshake", i), 32'(viol), 32'h0);
    end

    // Stalled response with a competing request held high.
    do_op(32, 3'd0, 32'h0001_0003, 32'h0000_0100, 10, r, lat, viol);
    check("bp_result", r, 32'h0100_0300);
    check("bp_handshake", 32'(viol), 32'h0);
    @(posedge clk); #1;
    check("bp_idle_after", {31'h0, busy32}, 32'h0);
    check("bp_r_kept", r32, 32'h0100_0300);

    // Asynchronous reset in the 10th RUN cycle discards the operation.
    drive(32, 1'b1, 3'd5, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", {29'h0, rdy32, rv32, busy32}, 32'h4);
    check("midrun_reset_r", r32, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    viol = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rv32 || busy32) viol++;
    end
    check("midrun_no_response", 32'(viol), 32'h0);
    do_op(32, 3'd5, 32'd100, 32'd7, 0, r, lat, viol);
    check("post_reset_divu", r, 32'd14);
    check("post_reset_latency", 32'(lat), 32'd33);

    // Random operations against the model, biased toward the division corner cases.
    for (int i = 0; i < 60; i++) begin
      w      = (i < 40) ? 32 : 16;
      unroll = (w == 32) ? 1 : 4;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: begin a = (w == 32) ? 32'h8000_0000 : 32'h0000_8000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      if (w == 16) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
      exp_q.push_back(model(w, op, a, b));
      do_op(w, op, a, b, $urandom_range(0, 2), r, lat, viol);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_w%0d_op%0d_a%08h_b%08h", i, w, op, a, b), r, e);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(model_lat(w, unroll, op, a, b)));
      check($sformatf("rnd%0d_handshake", i), 32'(viol), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
